// File: rtl/ib_ram_lut_loader_if.sv
// Stream-in / page-write bundle for the IB-RAM LUT loader.
// The master side drives the entry stream; the slave side is the loader itself.
interface ib_ram_lut_loader_if #(
   parameter int QUAN_SIZE       = 4,
   parameter int PAGE_SIZE       = 4,
   parameter int BANK_ADDR_WIDTH = 2,
   parameter int PAGE_ADDR_WIDTH = 6,
   parameter int ADDR_WIDTH      = 8
);
   logic                            load_start;
   logic                            in_valid;
   logic                            in_ready;
   logic [QUAN_SIZE-1:0]            in_data;
   logic                            in_last;
   logic                            wr_en;
   logic [ADDR_WIDTH-1:0]           wr_addr;
   logic [BANK_ADDR_WIDTH-1:0]      wr_bank;
   logic [PAGE_ADDR_WIDTH-1:0]      wr_page;
   logic [PAGE_SIZE*QUAN_SIZE-1:0]  wr_data;
   logic                            load_busy;
   logic                            load_done;
   logic                            overflow;
   logic [ADDR_WIDTH:0]             page_cnt;

   modport master (
      output load_start, in_valid, in_data, in_last,
      input  in_ready, wr_en, wr_addr, wr_bank, wr_page, wr_data,
             load_busy, load_done, overflow, page_cnt
   );

   modport slave (
      input  load_start, in_valid, in_data, in_last,
      output in_ready, wr_en, wr_addr, wr_bank, wr_page, wr_data,
             load_busy, load_done, overflow, page_cnt
   );
endinterface

// File: rtl/ib_ram_lut_loader.sv
// Packs a serial LUT-entry stream into page words and issues one registered
// IB-RAM write per page, with bank/page fields split by the interleave type.
module ib_ram_lut_loader #(
   parameter int QUAN_SIZE            = 4,
   parameter int BANK_INTERLEAVE_TYPE = 0,
   parameter int BANK_INTERLEAVE_NUM  = 4,
   parameter int BANK_ADDR_WIDTH      = 2,
   parameter int PAGE_ADDR_WIDTH      = 6,
   parameter int ADDR_WIDTH           = 8,
   parameter int PAGE_SIZE            = 4,
   parameter int PAGE_NUM             = 64
) (
   input logic                  sys_clk,
   input logic                  rst,
   ib_ram_lut_loader_if.slave   bus
);
   localparam int CAP_PAGES = BANK_INTERLEAVE_NUM * PAGE_NUM;
   localparam int IDX_W     = (PAGE_SIZE > 1) ? $clog2(PAGE_SIZE) : 1;
   localparam int DATA_W    = PAGE_SIZE * QUAN_SIZE;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

   state_t                      r_state;
   logic [IDX_W-1:0]            r_entry_idx;
   logic [DATA_W-1:0]           r_pack;
   logic [ADDR_WIDTH:0]         r_page_cnt;
   logic                        r_in_ready;
   logic                        r_wr_en;
   logic [ADDR_WIDTH-1:0]       r_wr_addr;
   logic [BANK_ADDR_WIDTH-1:0]  r_wr_bank;
   logic [PAGE_ADDR_WIDTH-1:0]  r_wr_page;
   logic [DATA_W-1:0]           r_wr_data;
   logic                        r_load_busy;
   logic                        r_load_done;
   logic                        r_overflow;

   logic                        w_accept;
   logic                        w_full;
   logic                        w_slot_last;
   logic [DATA_W-1:0]           w_pack_next;
   logic [ADDR_WIDTH-1:0]       w_lin;
   logic [BANK_ADDR_WIDTH-1:0]  w_bank;
   logic [PAGE_ADDR_WIDTH-1:0]  w_page;

   assign w_accept    = (r_state == S_LOAD) && r_in_ready && bus.in_valid;
   assign w_full      = (r_page_cnt == (ADDR_WIDTH+1)'(CAP_PAGES));
   assign w_slot_last = (r_entry_idx == IDX_W'(PAGE_SIZE-1));
   assign w_lin       = r_page_cnt[ADDR_WIDTH-1:0];

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_pack_next = r_pack;
      w_pack_next[int'(r_entry_idx)*QUAN_SIZE +: QUAN_SIZE] = bus.in_data;
   end

   // The linear page counter is the address in both modes; only the field split changes.
   always_comb begin
      if (BANK_INTERLEAVE_TYPE == 0) begin
         w_bank = w_lin[ADDR_WIDTH-1 -: BANK_ADDR_WIDTH];
         w_page = w_lin[PAGE_ADDR_WIDTH-1:0];
      end else begin
         w_bank = w_lin[BANK_ADDR_WIDTH-1:0];
         w_page = w_lin[ADDR_WIDTH-1 -: PAGE_ADDR_WIDTH];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_entry_idx <= '0;
         // NOTE: the pack register is a plain register, so it is reset; zero-padding relies on it starting clear.
         r_pack      <= '0;
         r_page_cnt  <= '0;
         r_in_ready  <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_bank   <= '0;
         r_wr_page   <= '0;
         r_wr_data   <= '0;
         r_load_busy <= 1'b0;
         r_load_done <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_wr_en     <= 1'b0;
         r_load_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (r_state == S_DONE) begin
                  r_load_done <= 1'b1;
                  r_state     <= S_IDLE;
               end
               if (bus.load_start) begin
                  r_state     <= S_LOAD;
                  r_entry_idx <= '0;
                  r_pack      <= '0;
                  r_page_cnt  <= '0;
                  r_overflow  <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_load_busy <= 1'b1;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  if (w_full) begin
                     // Capacity reached: discard the entry, never wrap the address.
                     r_overflow <= 1'b1;
                     if (bus.in_last) begin
                        r_state     <= S_DONE;
                        r_in_ready  <= 1'b0;
                        r_load_busy <= 1'b0;
                     end
                  end else if (w_slot_last) begin
                     r_wr_en     <= 1'b1;
                     r_wr_data   <= w_pack_next;
                     r_wr_addr   <= w_lin;
                     r_wr_bank   <= w_bank;
                     r_wr_page   <= w_page;
                     r_page_cnt  <= r_page_cnt + (ADDR_WIDTH+1)'(1);
                     r_entry_idx <= '0;
                     r_pack      <= '0;
                     if (bus.in_last) begin
                        r_state     <= S_DONE;
                        r_in_ready  <= 1'b0;
                        r_load_busy <= 1'b0;
                     end
                  end else begin
                     r_pack      <= w_pack_next;
                     r_entry_idx <= r_entry_idx + IDX_W'(1);
                     if (bus.in_last) begin
                        r_state    <= S_FLUSH;
                        r_in_ready <= 1'b0;
                     end
                  end
               end
            end
            S_FLUSH: begin
               // Unfilled slots are still zero from the per-page clear.
               r_wr_en     <= 1'b1;
               r_wr_data   <= r_pack;
               r_wr_addr   <= w_lin;
               r_wr_bank   <= w_bank;
               r_wr_page   <= w_page;
               r_page_cnt  <= r_page_cnt + (ADDR_WIDTH+1)'(1);
               r_entry_idx <= '0;
               r_pack      <= '0;
               r_state     <= S_DONE;
               r_load_busy <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.wr_en     = r_wr_en;
   assign bus.wr_addr   = r_wr_addr;
   assign bus.wr_bank   = r_wr_bank;
   assign bus.wr_page   = r_wr_page;
   assign bus.wr_data   = r_wr_data;
   assign bus.load_busy = r_load_busy;
   assign bus.load_done = r_load_done;
   assign bus.overflow  = r_overflow;
   assign bus.page_cnt  = r_page_cnt;
endmodule

// File: tb/tb_ib_ram_lut_loader.sv
// Drives one entry stream into a bank-major and a bank-rotating loader and
// scoreboards every page write against a queue-based packing model.
module tb_ib_ram_lut_loader;
   localparam int QS  = 4;
   localparam int PS  = 4;
   localparam int BN  = 4;
   localparam int BAW = 2;
   localparam int PAW = 6;
   localparam int AW  = 8;
   localparam int PN  = 64;
   localparam int CAP = BN * PN;
   localparam int DW  = PS * QS;

   typedef struct {
      int            lin;
      logic [DW-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_wr_cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ib_ram_lut_loader_if #(.QUAN_SIZE(QS), .PAGE_SIZE(PS), .BANK_ADDR_WIDTH(BAW),
                          .PAGE_ADDR_WIDTH(PAW), .ADDR_WIDTH(AW)) if0 ();
   ib_ram_lut_loader_if #(.QUAN_SIZE(QS), .PAGE_SIZE(PS), .BANK_ADDR_WIDTH(BAW),
                          .PAGE_ADDR_WIDTH(PAW), .ADDR_WIDTH(AW)) if1 ();

   assign if1.load_start = if0.load_start;
   assign if1.in_valid   = if0.in_valid;
   assign if1.in_data    = if0.in_data;
   assign if1.in_last    = if0.in_last;

   ib_ram_lut_loader #(.QUAN_SIZE(QS), .BANK_INTERLEAVE_TYPE(0), .BANK_INTERLEAVE_NUM(BN),
                       .BANK_ADDR_WIDTH(BAW), .PAGE_ADDR_WIDTH(PAW), .ADDR_WIDTH(AW),
                       .PAGE_SIZE(PS), .PAGE_NUM(PN))
      u_dut0 (.sys_clk(clk), .rst(rst), .bus(if0));

   ib_ram_lut_loader #(.QUAN_SIZE(QS), .BANK_INTERLEAVE_TYPE(1), .BANK_INTERLEAVE_NUM(BN),
                       .BANK_ADDR_WIDTH(BAW), .PAGE_ADDR_WIDTH(PAW), .ADDR_WIDTH(AW),
                       .PAGE_SIZE(PS), .PAGE_NUM(PN))
      u_dut1 (.sys_clk(clk), .rst(rst), .bus(if1));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a session is a list of entries; every PS entries form a page.
   wr_t        q0[$];
   wr_t        q1[$];
   logic [QS-1:0] m_cur[$];
   int         m_pages;
   bit         m_ovf;

   function automatic void model_reset();
      m_cur.delete();
      m_pages = 0;
      m_ovf   = 1'b0;
   endfunction

   function automatic void model_emit();
      wr_t w;
      w.lin  = m_pages;
      w.data = '0;
      foreach (m_cur[k]) w.data = w.data | (DW'(m_cur[k]) << (k * QS));
      q0.push_back(w);
      q1.push_back(w);
      m_pages++;
      m_cur.delete();
   endfunction

   function automatic void model_accept(input logic [QS-1:0] d, input bit last);
      if (m_pages == CAP) m_ovf = 1'b1;
      else begin
         m_cur.push_back(d);
         if (m_cur.size() == PS) model_emit();
      end
      if (last && m_cur.size() > 0) model_emit();
   endfunction

   // Monitors: bank-major mapping for dut0, bank-rotating mapping for dut1.
   always @(negedge clk) begin
      wr_t e;
      if (!rst && if0.wr_en) begin
         last_wr_cyc = cyc;
         if (q0.size() == 0) check("t0_unexpected_wr", {56'd0, if0.wr_addr}, 64'hFFFF);
         else begin
            e = q0.pop_front();
            check("t0_addr", 64'(if0.wr_addr), 64'(e.lin));
            check("t0_bank", 64'(if0.wr_bank), 64'(e.lin / PN));
            check("t0_page", 64'(if0.wr_page), 64'(e.lin % PN));
            check("t0_data", 64'(if0.wr_data), 64'(e.data));
         end
      end
   end

   always @(negedge clk) begin
      wr_t e;
      if (!rst && if1.wr_en) begin
         if (q1.size() == 0) check("t1_unexpected_wr", {56'd0, if1.wr_addr}, 64'hFFFF);
         else begin
            e = q1.pop_front();
            check("t1_addr", 64'(if1.wr_addr), 64'(e.lin));
            check("t1_bank", 64'(if1.wr_bank), 64'(e.lin % BN));
            check("t1_page", 64'(if1.wr_page), 64'(e.lin / BN));
            check("t1_data", 64'(if1.wr_data), 64'(e.data));
         end
      end
   end

   task automatic start_session();
      @(negedge clk);
      if0.load_start = 1'b1;
      model_reset();
      @(negedge clk);
      if0.load_start = 1'b0;
      check("start_ready", 64'(if0.in_ready), 64'd1);
   endtask

   task automatic send(input logic [QS-1:0] d, input bit last, input int gap, input bit pulse);
      int n;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         if0.in_valid   = 1'b0;
         if0.load_start = pulse && (g == 0);
      end
      @(negedge clk);
      if0.load_start = 1'b0;
      if0.in_valid   = 1'b1;
      if0.in_data    = d;
      if0.in_last    = last;
      n = 0;
      while (!if0.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!if0.in_ready) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got in_ready=0 after %0d cycles, want 1", n);
      end else model_accept(d, last);
      @(posedge clk);
      #1;
      if0.in_valid = 1'b0;
      if0.in_last  = 1'b0;
   endtask

   task automatic wait_done(output int done_cyc);
      int n = 0;
      @(negedge clk);
      while (!if0.load_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      done_cyc = cyc;
      check("done_seen", 64'(if0.load_done), 64'd1);
      check("done_pair", 64'(if1.load_done), 64'd1);
      check("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
      check("page_cnt0", 64'(if0.page_cnt), 64'(m_pages));
      check("page_cnt1", 64'(if1.page_cnt), 64'(m_pages));
      check("overflow0", 64'(if0.overflow), 64'(m_ovf));
      check("overflow1", 64'(if1.overflow), 64'(m_ovf));
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready",  64'(if0.in_ready  | if1.in_ready),  64'd0);
      check("rst_wr_en",     64'(if0.wr_en     | if1.wr_en),     64'd0);
      check("rst_wr_addr",   64'(if0.wr_addr   | if1.wr_addr),   64'd0);
      check("rst_wr_fields", 64'({if0.wr_bank, if0.wr_page} | {if1.wr_bank, if1.wr_page}), 64'd0);
      check("rst_wr_data",   64'(if0.wr_data   | if1.wr_data),   64'd0);
      check("rst_busy",      64'(if0.load_busy | if1.load_busy), 64'd0);
      check("rst_done",      64'(if0.load_done | if1.load_done), 64'd0);
      check("rst_overflow",  64'(if0.overflow  | if1.overflow),  64'd0);
      check("rst_page_cnt",  64'(if0.page_cnt  | if1.page_cnt),  64'd0);
   endtask

   initial begin
      int dc;
      if0.load_start = 1'b0;
      if0.in_valid   = 1'b0;
      if0.in_data    = '0;
      if0.in_last    = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;

      // Two full pages; done follows the second write by one cycle.
      start_session();
      for (int i = 1; i <= 8; i++) send(QS'(i), i == 8, 0, 1'b0);
      wait_done(dc);
      check("done_after_wr", 64'(dc - last_wr_cyc), 64'd1);
      check("busy_after_done", 64'(if0.load_busy), 64'd0);

      // Partial last page: one not-ready flush cycle, zero-padded write.
      start_session();
      for (int i = 0; i < 6; i++) send(QS'(10 + i), i == 5, 0, 1'b0);
      @(negedge clk);
      check("flush_not_ready", 64'(if0.in_ready), 64'd0);
      wait_done(dc);

      // 65 pages so page 64 exercises both field splits.
      start_session();
      for (int i = 0; i < 65 * PS; i++) send(QS'($urandom), i == 65 * PS - 1, 0, 1'b0);
      wait_done(dc);

      // Overflow: four entries past capacity are dropped, no wrap write.
      start_session();
      for (int i = 0; i < CAP * PS + 4; i++) send(QS'($urandom), i == CAP * PS + 3, 0, 1'b0);
      wait_done(dc);
      check("ovf_set", 64'(if0.overflow & if1.overflow), 64'd1);
      start_session();
      check("ovf_cleared", 64'(if0.overflow | if1.overflow), 64'd0);
      check("cnt_cleared", 64'(if0.page_cnt), 64'd0);

      // Reset mid-page aborts without a write.
      send(QS'(3), 1'b0, 0, 1'b0);
      send(QS'(5), 1'b0, 0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      q0.delete();
      q1.delete();
      model_reset();
      #1;
      check_reset_outputs();
      repeat (3) @(negedge clk);
      check("rst_no_write", 64'(if0.wr_en | if1.wr_en), 64'd0);
      rst = 1'b0;
      start_session();
      for (int i = 0; i < 4; i++) send(QS'(i + 7), i == 3, 0, 1'b0);
      wait_done(dc);

      // Random gaps with stray load_start pulses while loading.
      start_session();
      for (int i = 0; i < 42; i++) begin
         bit p = (i == 10) || (i == 25);
         int gap = p ? 1 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
         send(QS'($urandom), i == 41, gap, p);
         if (p) check("busy_kept", 64'(if0.load_busy & if1.load_busy), 64'd1);
      end
      wait_done(dc);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ib_ram_lut_loader.md
Name: ib_ram_lut_loader

Overview:
Upstream write-side loader for a bank-interleaved IB-RAM macro holding quantised IB LUT entries. It accepts a serial valid/ready stream of LUT entries in LUT-index order and packs PAGE_SIZE entries into one page word. It issues one registered write per page with a bank address and page address split according to the interleave type. It also handles partial-page flush on the last entry, capacity overflow, and load start/done sequencing.

Parameters:
QUAN_SIZE, 4, bit width of one LUT entry
BANK_INTERLEAVE_TYPE, 0, 0: waddr={bank_addr,page_addr} (bank-major fill); 1: waddr={page_addr,bank_addr} (consecutive pages rotate across banks)
BANK_INTERLEAVE_NUM, 4, number of interleaved banks
BANK_ADDR_WIDTH, 2, $clog2(BANK_INTERLEAVE_NUM)
PAGE_ADDR_WIDTH, 6, page address width per bank
ADDR_WIDTH, 8, BANK_ADDR_WIDTH+PAGE_ADDR_WIDTH
PAGE_SIZE, 4, LUT entries per page word
PAGE_NUM, 64, pages per bank (2**PAGE_ADDR_WIDTH)

Ports:
sys_clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
load_start  in  1  one-cycle pulse; begins a load session (ignored unless IDLE or DONE)
in_valid  in  1  entry valid
in_ready  out  1  loader can accept entry
in_data  in  QUAN_SIZE  LUT entry
in_last  in  1  marks final entry of session (qualified by in_valid&in_ready)
wr_en  out  1  one-cycle IB-RAM write strobe
wr_addr  out  ADDR_WIDTH  full write address, field order per BANK_INTERLEAVE_TYPE
wr_bank  out  BANK_ADDR_WIDTH  bank field of wr_addr
wr_page  out  PAGE_ADDR_WIDTH  page field of wr_addr
wr_data  out  PAGE_SIZE*QUAN_SIZE  packed page; entry k at bits [k*QUAN_SIZE +: QUAN_SIZE]
load_busy  out  1  high in LOAD/FLUSH
load_done  out  1  one-cycle pulse when session completes
overflow  out  1  sticky; entries offered beyond capacity
page_cnt  out  ADDR_WIDTH+1  pages written in current session

Behaviour:
- Reset values: all outputs 0; state IDLE. Internal counters cleared; pack register cleared. Reset mid-session aborts immediately with no write and no done pulse.
- Capacity: CAP_PAGES = BANK_INTERLEAVE_NUM*PAGE_NUM (default 256 pages = 1024 entries).
- FSM states and transitions:
  - IDLE: on load_start, clear counters and overflow, then go to LOAD.
  - LOAD: in_ready=1. A handshake stores in_data into slot entry_idx (0..PAGE_SIZE-1) and increments entry_idx.
    - When slot PAGE_SIZE-1 fills: wr_en=1 on the next cycle with the full page, linear page counter lin++, entry_idx=0.
    - If in_last coincides with a full page: write as above, then go to DONE.
    - If in_last arrives with the page partial: go to FLUSH.
  - FLUSH: in_ready=0 for this one cycle. Unfilled slots are zero-padded. wr_en=1 with the padded page, then go to DONE.
  - DONE: load_done=1 for one cycle, then IDLE. load_start in DONE is treated as in IDLE.
- Write latency: exactly 1 cycle from the accepting edge of the completing entry to wr_en high. Write and next-entry acceptance may overlap (no bubble in LOAD).
- Address mapping from linear page counter lin (ADDR_WIDTH bits):
  - TYPE 0: wr_bank=lin[ADDR_WIDTH-1 -: BANK_ADDR_WIDTH], wr_page=lin[PAGE_ADDR_WIDTH-1:0], wr_addr={wr_bank,wr_page}.
  - TYPE 1: wr_bank=lin[BANK_ADDR_WIDTH-1:0], wr_page=lin[ADDR_WIDTH-1 -: PAGE_ADDR_WIDTH], wr_addr={wr_page,wr_bank}.
  - In both types wr_addr == lin; the field semantics differ.
- page_cnt increments with each wr_en and holds after DONE until the next load_start.
- Overflow: after CAP_PAGES writes, in_ready stays 1 but entries are discarded and overflow sets (sticky). No wrap-around write. in_last still terminates the session with no flush write.
- wr_addr/wr_bank/wr_page/wr_data hold their last value when wr_en=0.
- load_start while busy: ignored.
- in_valid outside LOAD: ignored (in_ready=0).

Test Plan:
1. TYPE 0 default params; start, stream 8 entries 0x1..0x8, last on 8th -> two writes: wr_addr 0x00 data 0x4321, wr_addr 0x01 data 0x8765; load_done 1 cycle after second wr_en; page_cnt=2.
2. Partial page: 6 entries 0xA..0xF, last on 6th -> write 0x00 data 0xDCBA; FLUSH cycle with in_ready=0; write 0x01 data 0x00FE; done.
3. TYPE 1: stream 65 pages -> page 64 written with wr_bank=0, wr_page=16, wr_addr=0x40; TYPE 0 same lin gives wr_bank=1, wr_page=0.
4. Overflow: 1028 entries with last on final -> 256 writes, last wr_addr 0xFF; overflow=1; no wrap to 0x00; done pulses; next load_start clears overflow.
5. Reset asserted after 2 entries of a page -> all outputs 0 at once, no wr_en; new session starts writing at wr_addr 0x00.
6. Random in_valid gaps, and load_start pulsed mid-LOAD -> pack order unchanged, session not restarted, write data matches a reference packing model.
